osc_freq_counter: RTL and testbench

Digital measurement stage directly downstream of the relaxation oscillator. It takes the squared-up oscillator output on a digital input pin. It synchronises that signal into the clk domain and counts its rising edges over a fixed gate window of clk cycles. It then publishes the count for readout on the dedicated outputs. The result is a frequency measurement, f_osc = count * f_clk / GATE_CYCLES, so the oscillator can be characterised on silicon without a scope.

---
 rtl/osc_freq_counter_if.sv | 23 ++
 rtl/osc_freq_counter.sv | 123 ++++++++++++
 tb/tb_osc_freq_counter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/osc_freq_counter_if.sv
// Control inputs and result outputs of the oscillator frequency counter.
interface osc_freq_counter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             ena;
    logic             osc_in;
    logic             start;
    logic             cont;
    logic [WIDTH-1:0] count_out;
    logic             overflow;
    logic             valid;
    logic             busy;

    modport master (
        output ena, osc_in, start, cont,
        input  count_out, overflow, valid, busy
    );

    modport slave (
        input  ena, osc_in, start, cont,
        output count_out, overflow, valid, busy
    );
endinterface

// File: rtl/osc_freq_counter.sv
// Counts synchronised osc_in rising edges over a GATE_CYCLES window and publishes the result.
// Result appears one cycle after DONE with a valid strobe; start while busy is dropped.
module osc_freq_counter #(
    parameter int unsigned GATE_CYCLES = 1000000,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    osc_freq_counter_if.slave  bus
);
    localparam int unsigned    TW         = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]  TIMER_INIT = TW'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   edge_q, edge_d;
    logic [WIDTH-1:0]       edge_cnt_q, edge_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;

    // Edge pulse is registered so osc_in -> pulse is SYNC_STAGES+1 edges.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.osc_in};
        prev_d = sync_q[SYNC_STAGES-1];
        edge_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        timer_d    = timer_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start || bus.cont) begin
                    state_d    = GATE;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                    timer_d    = TIMER_INIT;
                end
            end
            GATE: begin
                if (edge_q) begin
                    if (edge_cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
                if (timer_q == '0) begin
                    state_d = DONE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DONE: begin
                count_d    = edge_cnt_q;
                overflow_d = ovf_q;
                valid_d    = 1'b1;
                if (bus.cont) begin
                    state_d    = GATE;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                    timer_d    = TIMER_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable overrides everything: abort without publishing.
        if (!bus.ena) begin
            state_d    = IDLE;
            count_d    = count_q;
            overflow_d = overflow_q;
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            edge_q     <= 1'b0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            timer_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            edge_q     <= edge_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.count_out = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_osc_freq_counter.sv
// Bench for osc_freq_counter: DUT A (GATE=16, WIDTH=8) and DUT B (GATE=64, WIDTH=4) share clk/rst/osc.
module tb_osc_freq_counter;
    typedef struct {
        int lo;
        int hi;
        int ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic osc;
    int   osc_half = 0;
    int   ocnt = 0;
    int   checks = 0;
    int   failures = 0;
    int   va_count = 0;
    int   vb_count = 0;
    exp_t qa[$];
    exp_t qb[$];

    osc_freq_counter_if #(.WIDTH(8)) ia();
    osc_freq_counter_if #(.WIDTH(4)) ib();

    assign ia.osc_in = osc;
    assign ib.osc_in = osc;

    osc_freq_counter #(.GATE_CYCLES(16), .WIDTH(8), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia)
    );
    osc_freq_counter #(.GATE_CYCLES(64), .WIDTH(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] got, input int lo, input int hi);
        checks++;
        assert ((got >= lo && got <= hi) === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=[%0d:%0d]", tag, got, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Oscillator model: toggles every osc_half clk periods, static when osc_half==0.
    initial begin
        forever begin
            @(negedge clk);
            if (osc_half != 0) begin
                ocnt++;
                if (ocnt >= osc_half) begin
                    osc  = ~osc;
                    ocnt = 0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ia.valid === 1'b1) begin
                va_count++;
                chk("a_valid_expected", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk_rng("a_count_out", ia.count_out, e.lo, e.hi);
                    chk("a_overflow", ia.overflow, e.ovf);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ib.valid === 1'b1) begin
                vb_count++;
                chk("b_valid_expected", qb.size() > 0, 1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    chk_rng("b_count_out", ib.count_out, e.lo, e.hi);
                    chk("b_overflow", ib.overflow, e.ovf);
                end
            end
        end
    end

    initial begin
        int seen;
        int busy_cnt;
        int va0;
        int busy_hi;
        int vpos[$];

        // Reset with osc high and start asserted.
        rst_n = 1'b0; osc = 1'b1; osc_half = 0;
        ia.ena = 1'b1; ia.start = 1'b1; ia.cont = 1'b0;
        ib.ena = 1'b1; ib.start = 1'b1; ib.cont = 1'b0;
        tick(3);
        chk("rst_a_count", ia.count_out, 0);
        chk("rst_a_ovf", ia.overflow, 0);
        chk("rst_a_valid", ia.valid, 0);
        chk("rst_a_busy", ia.busy, 0);
        chk("rst_b_count", ib.count_out, 0);
        chk("rst_b_ovf", ib.overflow, 0);
        chk("rst_b_valid", ib.valid, 0);
        chk("rst_b_busy", ib.busy, 0);
        rst_n = 1'b1; ia.start = 1'b0; ib.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ia.busy !== 1'b0 || ia.valid !== 1'b0 || ib.busy !== 1'b0 || ib.valid !== 1'b0) seen++;
        end
        chk("idle_after_reset", seen, 0);

        // Single measurement: period 4 -> 4 edges in 16 cycles.
        osc_half = 2; ocnt = 0;
        tick(20);
        qa.push_back('{4, 4, 0});
        va0 = va_count; busy_cnt = 0;
        ia.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ia.start = 1'b0;
            if (ia.busy === 1'b1) busy_cnt++;
        end
        chk("single_busy_cycles", busy_cnt, 17);
        chk("single_valid_count", va_count - va0, 1);

        // Saturation on DUT B: 32 edges into a 4-bit counter.
        osc_half = 1; ocnt = 0;
        tick(10);
        qb.push_back('{15, 15, 1});
        ib.start = 1'b1; tick(1); ib.start = 1'b0;
        tick(80);
        chk("sat_count", ib.count_out, 15);
        chk("sat_ovf", ib.overflow, 1);
        osc_half = 0; osc = 1'b0;
        tick(10);
        qb.push_back('{0, 0, 0});
        ib.start = 1'b1; tick(1); ib.start = 1'b0;
        tick(80);
        chk("static_count", ib.count_out, 0);
        chk("static_ovf", ib.overflow, 0);

        // Continuous mode: period 8, valid every 17 cycles, cont dropped mid-GATE of the 4th run.
        osc_half = 4; ocnt = 0;
        tick(20);
        for (int i = 0; i < 4; i++) qa.push_back('{2, 3, 0});
        busy_hi = 0;
        ia.cont = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 59) ia.cont = 1'b0;
            if (i <= 68 && ia.busy === 1'b1) busy_hi++;
            if (i == 69) chk("cont_busy_drop", ia.busy, 0);
            if (ia.valid === 1'b1) vpos.push_back(i);
        end
        chk("cont_busy_held", busy_hi, 68);
        chk("cont_valid_num", vpos.size(), 4);
        if (vpos.size() == 4) begin
            chk("cont_first_valid", vpos[0], 18);
            for (int i = 0; i < 3; i++) chk("cont_valid_period", vpos[i+1] - vpos[i], 17);
        end

        // Reset at GATE cycle 8 discards the partial count.
        osc_half = 2; ocnt = 0;
        tick(5);
        ia.start = 1'b1; tick(1); ia.start = 1'b0;
        tick(7);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_count", ia.count_out, 0);
        chk("midrst_ovf", ia.overflow, 0);
        chk("midrst_valid", ia.valid, 0);
        chk("midrst_busy", ia.busy, 0);
        rst_n = 1'b1;
        va0 = va_count;
        tick(30);
        chk("midrst_no_valid", va_count - va0, 0);

        // ena=0 at GATE cycle 8: abort, previous result held.
        qa.push_back('{4, 4, 0});
        ia.start = 1'b1; tick(1); ia.start = 1'b0;
        tick(40);
        chk("pre_abort_count", ia.count_out, 4);
        va0 = va_count;
        ia.start = 1'b1; tick(1); ia.start = 1'b0;
        tick(7);
        ia.ena = 1'b0;
        tick(1);
        chk("abort_busy", ia.busy, 0);
        chk("abort_count_held", ia.count_out, 4);
        chk("abort_valid", ia.valid, 0);
        tick(30);
        chk("abort_no_valid", va_count - va0, 0);
        chk("abort_count_still", ia.count_out, 4);
        ia.ena = 1'b1;

        // start held through the whole GATE with osc static: one measurement only.
        osc_half = 0; osc = 1'b0;
        tick(10);
        qa.push_back('{0, 0, 0});
        va0 = va_count;
        ia.start = 1'b1; tick(16); ia.start = 1'b0;
        tick(30);
        chk("held_start_valids", va_count - va0, 1);
        chk("held_start_count", ia.count_out, 0);

        // Edges only while idle are not counted.
        osc_half = 2; ocnt = 0;
        tick(20);
        osc_half = 0; osc = 1'b0;
        tick(10);
        qa.push_back('{0, 0, 0});
        va0 = va_count;
        ia.start = 1'b1; tick(1); ia.start = 1'b0;
        tick(30);
        chk("idle_edges_valids", va_count - va0, 1);
        chk("idle_edges_count", ia.count_out, 0);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
